// File: rtl/ram_generate_offset_n.sv
// Accepts a frame of CH_NUM packed channels, adds OFFSET to each channel and
// presents the results in two ways: as a parallel bus, then as a valid/ready
// serial stream of one channel per word.
// Define RAM_GEN_SAT_EN to saturate the sum instead of letting it wrap.
module ram_generate_offset_n #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 8,
  parameter int OFFSET = 10,
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [CH_NUM*DATA_W-1:0] out_data,
  output logic                     ser_valid,
  input  logic                     ser_ready,
  output logic [DATA_W-1:0]        ser_data,
  output logic [CH_W-1:0]          ser_ch,
  output logic                     ser_last
);

  // Handshakes: a transfer happens on any posedge where valid && ready.
  // in_valid is dropped unless in_ready; ser_data/ser_ch/ser_last hold until taken.

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  localparam logic [DATA_W:0]   OFF_EXT = (DATA_W+1)'(OFFSET);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CH_NUM - 1);

  state_t                     state;
  state_t                     state_next;
  logic [DATA_W-1:0]          arr [CH_NUM];
  logic [CH_NUM*DATA_W-1:0]   sum_bus;
  logic [CH_W-1:0]            next_ch;
  logic                       accept;
  logic                       handshake;

  function automatic logic [DATA_W-1:0] add_off(input logic [DATA_W-1:0] d);
    logic [DATA_W:0] s;
    s = {1'b0, d} + OFF_EXT;
`ifdef RAM_GEN_SAT_EN
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  always_comb begin
    sum_bus = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      sum_bus[k*DATA_W +: DATA_W] = add_off(in_data[k*DATA_W +: DATA_W]);
    end
  end

  assign accept    = (state == IDLE) && in_valid;
  assign handshake = (state == SEND) && ser_valid && ser_ready;
  assign next_ch   = ser_ch + CH_W'(1);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SEND;
      end
      SEND: begin
        if (handshake && ser_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ser_ch doubles as the read index into arr while streaming.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < CH_NUM; k++) arr[k] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ser_valid <= 1'b0;
      ser_data  <= '0;
      ser_ch    <= '0;
      ser_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        for (int k = 0; k < CH_NUM; k++) arr[k] <= sum_bus[k*DATA_W +: DATA_W];
        out_data  <= sum_bus;
        out_valid <= 1'b1;
        ser_valid <= 1'b1;
        ser_data  <= sum_bus[DATA_W-1:0];
        ser_ch    <= '0;
        ser_last  <= 1'b0;
      end else if (handshake) begin
        if (ser_last) begin
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
        end else begin
          ser_ch   <= next_ch;
          ser_data <= arr[next_ch];
          ser_last <= (next_ch == LAST_CH);
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_generate_offset_n.sv
// Bench for ram_generate_offset_n: directed test-plan frames, then random frames
// with random serial back-pressure, checked against an arithmetic reference model.
module tb_ram_generate_offset_n;

  localparam int CH_NUM = 4;
  localparam int DATA_W = 8;
  localparam int OFFSET = 10;
  localparam int CH_W   = 2;
  localparam int BW     = CH_NUM * DATA_W;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [BW-1:0]     in_data;
  logic              out_valid;
  logic [BW-1:0]     out_data;
  logic              ser_valid;
  logic              ser_ready;
  logic [DATA_W-1:0] ser_data;
  logic [CH_W-1:0]   ser_ch;
  logic              ser_last;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [BW-1:0]     exp_out;

  ram_generate_offset_n #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .OFFSET(OFFSET)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_data  (ser_data),
    .ser_ch    (ser_ch),
    .ser_last  (ser_last)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference: plain integer sum, then clamp or modulo.
  function automatic logic [DATA_W-1:0] ref_ch(input int unsigned d);
    int unsigned s;
    int unsigned maxv;
    maxv = (1 << DATA_W) - 1;
    s = d + OFFSET;
`ifdef RAM_GEN_SAT_EN
    if (s > maxv) s = maxv;
`else
    s = s % (1 << DATA_W);
`endif
    return s[DATA_W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic do_accept(input logic [BW-1:0] d);
    logic [BW-1:0] m;
    m = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      m[k*DATA_W +: DATA_W] = ref_ch(int'(d[k*DATA_W +: DATA_W]));
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge sys_clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    exp_out  = m;
    exp_q.delete();
    for (int k = 0; k < CH_NUM; k++) exp_q.push_back(m[k*DATA_W +: DATA_W]);
    check("out_valid_pulse", out_valid, 1);
    check("out_data", out_data, exp_out);
  endtask

  // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic run_stream(input int mode, input bit pulse_in, input int stop_after);
    int hs;
    int cyc;
    int ch;
    bit r;
    hs = 0;
    cyc = 0;
    ch = 0;
    while (hs < stop_after && cyc < 100) begin
      if (cyc > 0) check("out_valid_low", out_valid, 0);
      check("out_data_hold", out_data, exp_out);
      check("in_ready_send", in_ready, 0);
      check("ser_valid", ser_valid, 1);
      check("ser_data", ser_data, exp_q[0]);
      check("ser_ch", ser_ch, ch);
      check("ser_last", ser_last, (ch == CH_NUM - 1));
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ser_ready = r;
      in_valid  = pulse_in && (cyc == 1);
      in_data   = 32'h0101_0101;
      @(negedge sys_clk);
      cyc++;
      if (r) begin
        void'(exp_q.pop_front());
        ch++;
        hs++;
      end
    end
    ser_ready = 1'b0;
    in_valid  = 1'b0;
    check("handshake_count", hs, stop_after);
  endtask

  task automatic check_stream_end();
    check("ser_valid_end", ser_valid, 0);
    check("ser_last_end", ser_last, 0);
    check("in_ready_back", in_ready, 1);
    check("out_data_kept", out_data, exp_out);
  endtask

  initial begin
    logic [BW-1:0] d;
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ser_ready = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_ser_ch", ser_ch, 0);
    check("rst_ser_last", ser_last, 0);

    // Test-plan frame with its literal expected result.
    do_accept(32'hFF00_03FA);
`ifdef RAM_GEN_SAT_EN
    check("tp_out_data", out_data, 64'hFF0A_0DFF);
`else
    check("tp_out_data", out_data, 64'h090A_0D04);
`endif
    run_stream(0, 1'b0, CH_NUM);
    check_stream_end();

    // Back-pressure 1,0,0 with an ignored in_valid pulse during SEND.
    do_accept(32'h00FF_F680);
    run_stream(1, 1'b1, CH_NUM);
    check_stream_end();

    do_accept(32'h0101_0101);
    check("tp_out_0b", out_data, 64'h0B0B_0B0B);
    run_stream(1, 1'b0, CH_NUM);
    check_stream_end();

    // Random frames, biased toward values near the carry boundary.
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < CH_NUM; k++) begin
        if ($urandom_range(0, 2) == 0) d[k*DATA_W +: DATA_W] = 8'(256 - OFFSET + $urandom_range(0, 2) - 1);
        else d[k*DATA_W +: DATA_W] = 8'($urandom);
      end
      do_accept(d);
      run_stream(2, 1'($urandom_range(0, 1)), CH_NUM);
      check_stream_end();
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    end

    // Reset after the second serial word aborts the stream.
    do_accept(32'($urandom));
    run_stream(0, 1'b0, 2);
    sys_rst_n = 1'b0;
    ser_ready = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check("abort_ser_valid", ser_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check("abort_no_words", ser_valid, 0);
    end
    ser_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
